// File: rtl/inst_loader.sv
// Boot loader: unpacks SYNC/CNT/data/CSUM byte frames into 32-bit
// little-endian instruction ROM writes and gates core reset on success.
module inst_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0]   MAX_CNT  = 17'd1 << ADDR_W;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        b0_q, b0_d;
  logic [7:0]        b1_q, b1_d;
  logic [7:0]        b2_q, b2_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic acc;
  logic timed;
  logic last_word;
  logic [15:0] cnt_new;

  // The receiver is never back-pressured; every offered byte is taken.
  assign in_ready = 1'b1;
  assign acc      = in_valid;
  assign timed    = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign cnt_new  = {in_data, cnt_q[7:0]};
  assign last_word = (17'(word_q) + 17'd1) == {1'b0, cnt_q};

  // Next-state, datapath and write-strobe generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    lane_d  = lane_q;
    csum_d  = csum_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    tmo_d   = (acc || !timed) ? '0 : tmo_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (acc && in_data == SYNC_BYTE) begin
          state_d = S_LEN0;
          word_d  = '0;
          lane_d  = '0;
          csum_d  = '0;
        end
      end
      S_LEN0: begin
        if (acc) begin
          cnt_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (acc) begin
          cnt_d = cnt_new;
          if ({1'b0, cnt_new} > MAX_CNT) state_d = S_ERR;
          else if (cnt_new == '0)        state_d = S_CSUM;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (acc) begin
          csum_d = csum_q + in_data;
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: b0_d = in_data;
            2'd1: b1_d = in_data;
            2'd2: b2_d = in_data;
            default: begin
              we_d    = 1'b1;
              waddr_d = word_q;
              wdata_d = {in_data, b2_q, b1_q, b0_q};
              word_d  = word_q + 1'b1;
              if (last_word) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (acc) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    if (timed && !acc && tmo_q == TMO_LAST) state_d = S_ERR;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      csum_q  <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      csum_q  <= csum_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rom_we    = we_q;
  assign rom_waddr = waddr_q;
  assign rom_wdata = wdata_q;
  assign cpu_hold  = (state_q != S_DONE);
  assign load_done = (state_q == S_DONE);
  assign load_err  = (state_q == S_ERR);

endmodule
